// File: rtl/ddr3_sup_pkg.sv
// Shared types and constants for the DDR3 calibration supervisor.
// Optional IRQ block is enabled by defining DDR3_SUP_IRQ_EN.
package ddr3_sup_pkg;

  typedef enum logic [2:0] {
    S_HOLD     = 3'd0,
    S_WAIT_CAL = 3'd1,
    S_READY    = 3'd2,
    S_BACKOFF  = 3'd3,
    S_FAILED   = 3'd4,
    S_LOST     = 3'd5
  } sup_state_e;

  localparam logic [1:0] A_STATUS = 2'd0;
  localparam logic [1:0] A_COUNT  = 2'd1;
  localparam logic [1:0] A_CTRL   = 2'd2;
  localparam logic [1:0] A_IRQ    = 2'd3;

  localparam int STS_CAL_LSB   = 0;
  localparam int STS_STATE_LSB = 4;
  localparam int STS_READY     = 8;

  localparam int CTRL_RESTART = 0;
  localparam int CTRL_IRQ_EN  = 1;

  localparam int IRQ_READY_RISE = 0;
  localparam int IRQ_FAILED     = 1;
  localparam int IRQ_LOST       = 2;

  localparam int ST_INIT = 0;
  localparam int ST_SUCC = 1;
  localparam int ST_FAIL = 2;

endpackage

// File: rtl/ddr3_sup_sync.sv
// Parameterised-width two-flop synchronizer.
// Both stages reset to zero.
module ddr3_sup_sync
  import ddr3_sup_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/ddr3_cal_supervisor.sv
// DDR3 bring-up/recovery supervisor with a 4-word Avalon-MM slave.
// Define DDR3_SUP_IRQ_EN to include the IRQ register and irq output.
module ddr3_cal_supervisor
  import ddr3_sup_pkg::*;
#(
  parameter int HOLD_CYCLES    = 64,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int MAX_RETRIES    = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [2:0]  cal_status,
  output logic        emif_soft_reset_n,
  output logic        mem_ready,
  output logic        irq
);

  localparam logic [31:0] HOLD_LAST = 32'(HOLD_CYCLES - 1);
  localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRIES);

  logic [2:0] cal_sync;

  ddr3_sup_sync #(.W(3)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (cal_status),
    .q       (cal_sync)
  );

  logic fail_s;
  logic good_s;
  assign fail_s = cal_sync[ST_FAIL];
  assign good_s = cal_sync[ST_INIT] & cal_sync[ST_SUCC] & ~fail_s;

  logic wr_ctrl;
  logic restart;
  assign wr_ctrl = write && (address == A_CTRL);
  assign restart = wr_ctrl && writedata[CTRL_RESTART];

  sup_state_e  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [3:0]  retry_q, retry_d;
  logic [7:0]  fev_q, fev_d;
  logic        emif_q, emif_d;
  logic        rdy_q, rdy_d;
  logic [31:0] rd_q, rd_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    fev_d   = fev_q;
    unique case (state_q)
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = S_WAIT_CAL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_WAIT_CAL: begin
        if (good_s) begin
          state_d = S_READY;
          cnt_d   = '0;
        end else if (fail_s || cnt_q == TMO_LAST) begin
          state_d = S_BACKOFF;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_BACKOFF: begin
        if (retry_q < RETRY_MAX) begin
          retry_d = retry_q + 4'd1;
          state_d = S_HOLD;
        end else begin
          state_d = S_FAILED;
        end
      end
      S_READY: begin
        if (!good_s) state_d = S_LOST;
      end
      S_LOST: begin
        retry_d = '0;
        state_d = S_HOLD;
      end
      S_FAILED: begin
        state_d = S_FAILED;
      end
      default: begin
        state_d = S_HOLD;
        cnt_d   = '0;
      end
    endcase
    if (restart) begin
      state_d = S_HOLD;
      cnt_d   = '0;
      retry_d = '0;
    end
    // counts entries, so a restart out of WAIT_CAL never bumps it
    if (state_d == S_BACKOFF && state_q != S_BACKOFF
        && fev_q != 8'hFF)
      fev_d = fev_q + 8'd1;
  end

  assign emif_d = !(state_d == S_HOLD || state_d == S_FAILED);
  assign rdy_d  = (state_d == S_READY);

  logic [2:0] irq_flags;
  logic       irq_en;
  logic       unused_wd;

`ifdef DDR3_SUP_IRQ_EN
  logic [2:0] irqf_q, irqf_d;
  logic       irq_en_q, irq_en_d;
  logic       irq_q, irq_d;
  logic [2:0] irq_set;

  always_comb begin
    irq_set = '0;
    irq_set[IRQ_READY_RISE] = (state_d == S_READY)
                              && (state_q != S_READY);
    irq_set[IRQ_FAILED]     = (state_d == S_FAILED)
                              && (state_q != S_FAILED);
    irq_set[IRQ_LOST]       = (state_d == S_LOST)
                              && (state_q != S_LOST);
    irq_en_d = irq_en_q;
    if (wr_ctrl) irq_en_d = writedata[CTRL_IRQ_EN];
    irqf_d = irqf_q;
    if (write && address == A_IRQ)
      irqf_d = irqf_d & ~writedata[2:0];
    irqf_d = irqf_d | irq_set;
    irq_d  = |(irqf_q & {3{irq_en_q}});
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqf_q   <= '0;
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irqf_q   <= irqf_d;
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  assign irq_flags = irqf_q;
  assign irq_en    = irq_en_q;
  assign irq       = irq_q;
  assign unused_wd = ^writedata[31:3];
`else
  assign irq_flags = '0;
  assign irq_en    = 1'b0;
  assign irq       = 1'b0;
  assign unused_wd = ^writedata[31:1];
`endif

  always_comb begin
    rd_d = rd_q;
    if (read) begin
      rd_d = '0;
      unique case (1'b1)
        (address == A_STATUS): begin
          rd_d[STS_CAL_LSB +: 3]   = cal_sync;
          rd_d[STS_STATE_LSB +: 3] = state_q;
          rd_d[STS_READY]          = rdy_q;
        end
        (address == A_COUNT): begin
          rd_d[3:0]  = retry_q;
          rd_d[15:8] = fev_q;
        end
        (address == A_CTRL): begin
          rd_d[CTRL_IRQ_EN] = irq_en;
        end
        default: begin
          rd_d[2:0] = irq_flags;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_HOLD;
      cnt_q   <= '0;
      retry_q <= '0;
      fev_q   <= '0;
      emif_q  <= 1'b0;
      rdy_q   <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      fev_q   <= fev_d;
      emif_q  <= emif_d;
      rdy_q   <= rdy_d;
      rd_q    <= rd_d;
    end
  end

  assign readdata          = rd_q;
  assign emif_soft_reset_n = emif_q;
  assign mem_ready         = rdy_q;

endmodule

// File: tb/tb_ddr3_cal_supervisor.sv
// Self-checking bench for ddr3_cal_supervisor.
// Expectations follow DDR3_SUP_IRQ_EN when it is defined.
module tb_ddr3_cal_supervisor;

  localparam int HC = 4;
  localparam int TO = 100;
  localparam int MR = 2;
`ifdef DDR3_SUP_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [1:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [2:0]  cal_status = '0;
  logic        emif_soft_reset_n;
  logic        mem_ready;
  logic        irq;

  ddr3_cal_supervisor #(
    .HOLD_CYCLES    (HC),
    .TIMEOUT_CYCLES (TO),
    .MAX_RETRIES    (MR)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .address           (address),
    .read              (read),
    .write             (write),
    .writedata         (writedata),
    .readdata          (readdata),
    .cal_status        (cal_status),
    .emif_soft_reset_n (emif_soft_reset_n),
    .mem_ready         (mem_ready),
    .irq               (irq)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: phase number, time spent in the phase,
  // retries, failure events, and a 2-deep input delay line.
  int          m_ph = 0;
  int          m_t = 0;
  int          m_retry = 0;
  int          m_fev = 0;
  bit [2:0]    m_ir = '0;
  bit          m_en = 1'b0;
  bit          m_irq = 1'b0;
  bit [31:0]   m_rd = '0;
  bit [2:0]    m_dly [2] = '{3'b0, 3'b0};

  task automatic model_reset();
    m_ph = 0; m_t = 0; m_retry = 0; m_fev = 0;
    m_ir = '0; m_en = 1'b0; m_irq = 1'b0; m_rd = '0;
    m_dly[0] = '0; m_dly[1] = '0;
  endtask

  function automatic bit [31:0] reg_val(input logic [1:0] a);
    bit [31:0] v = '0;
    case (a)
      2'd0: v = {23'd0, (m_ph == 2), 1'b0, 3'(m_ph),
                 1'b0, m_dly[1]};
      2'd1: v = {16'd0, 8'(m_fev), 4'd0, 4'(m_retry)};
      2'd2: v = {30'd0, m_en, 1'b0};
      default: v = {29'd0, m_ir};
    endcase
    return v;
  endfunction

  task automatic model_step();
    bit [2:0] s;
    bit fl, gd, rs;
    int np;
    s  = m_dly[1];
    fl = s[2];
    gd = s[0] && s[1] && !s[2];
    rs = write && address == 2'd2 && writedata[0];
    np = m_ph;
    if (read) m_rd = reg_val(address);
    m_irq = IRQ_ON && ((m_ir & {3{m_en}}) != 0);
    if (IRQ_ON && write && address == 2'd3)
      m_ir = m_ir & ~writedata[2:0];
    if (IRQ_ON && write && address == 2'd2)
      m_en = writedata[1];
    if (rs) begin
      np = 0;
      m_retry = 0;
    end else if (m_ph == 0) begin
      if (m_t == HC - 1) np = 1;
    end else if (m_ph == 1) begin
      if (gd) np = 2;
      else if (fl || m_t == TO - 1) np = 3;
    end else if (m_ph == 3) begin
      if (m_retry < MR) begin
        m_retry++;
        np = 0;
      end else np = 4;
    end else if (m_ph == 2) begin
      if (!gd) np = 5;
    end else if (m_ph == 5) begin
      m_retry = 0;
      np = 0;
    end
    if (np == 3 && m_ph != 3 && m_fev < 255) m_fev++;
    if (IRQ_ON && np != m_ph) begin
      if (np == 2) m_ir[0] = 1'b1;
      if (np == 4) m_ir[1] = 1'b1;
      if (np == 5) m_ir[2] = 1'b1;
    end
    m_t = (rs || np != m_ph) ? 0 : m_t + 1;
    m_ph = np;
    m_dly[1] = m_dly[0];
    m_dly[0] = cal_status;
  endtask

  always @(posedge clk) begin
    #1;
    if (!reset_n) model_reset();
    else model_step();
    chk("emif_n", {31'd0, emif_soft_reset_n},
        {31'd0, !(m_ph == 0 || m_ph == 4)});
    chk("mem_ready", {31'd0, mem_ready}, {31'd0, m_ph == 2});
    chk("irq", {31'd0, irq}, {31'd0, m_irq});
    chk("readdata", readdata, m_rd);
  end

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; write = 1'b1;
    @(negedge clk);
    write = 1'b0; writedata = '0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a; read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    d = readdata;
  endtask

  task automatic do_reset(input logic [2:0] cal);
    @(negedge clk);
    reset_n = 1'b0;
    cal_status = cal;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_ready(input int lim);
    int n = 0;
    while (mem_ready !== 1'b1 && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", {31'd0, mem_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit hit");
    $fatal(1);
  end

  logic [31:0] v;
  int          n;

  initial begin
    #2 reset_n = 1'b0;
    #1;
    chk("rst_readdata", readdata, 32'd0);
    chk("rst_emif", {31'd0, emif_soft_reset_n}, 32'd0);
    chk("rst_ready", {31'd0, mem_ready}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // normal bring-up
    repeat (3) @(posedge clk);
    #1 chk("hold_len_lo", {31'd0, emif_soft_reset_n}, 32'd0);
    @(posedge clk);
    #1 chk("hold_len_hi", {31'd0, emif_soft_reset_n}, 32'd1);
    repeat (6) @(negedge clk);
    cal_status = 3'b011;
    repeat (2) @(posedge clk);
    #1 chk("sync_lat_lo", {31'd0, mem_ready}, 32'd0);
    @(posedge clk);
    #1 chk("sync_lat_hi", {31'd0, mem_ready}, 32'd1);
    rd(2'd0, v); chk("status_ready", v, 32'h123);
    rd(2'd3, v); chk("irq_ready", v, IRQ_ON ? 32'd1 : 32'd0);
    wr(2'd2, 32'd2);
    @(posedge clk);
    #1 chk("irq_out_on", {31'd0, irq}, {31'd0, IRQ_ON});
    rd(2'd2, v); chk("ctrl_rd", v, IRQ_ON ? 32'd2 : 32'd0);

    // persistent fail
    do_reset(3'b100);
    repeat (40) @(negedge clk);
    rd(2'd1, v); chk("count_fail", v, 32'h0302);
    rd(2'd0, v); chk("status_fail", v, 32'h044);
    chk("emif_failed", {31'd0, emif_soft_reset_n}, 32'd0);
    rd(2'd3, v); chk("irq_failed", v, IRQ_ON ? 32'd2 : 32'd0);

    // fail and success together
    do_reset(3'b111);
    repeat (40) @(negedge clk);
    rd(2'd1, v); chk("count_111", v, 32'h0302);
    rd(2'd0, v); chk("status_111", v, 32'h047);

    // timeout
    do_reset(3'b000);
    n = 0;
    while (emif_soft_reset_n !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (emif_soft_reset_n === 1'b1 && n < 300) begin
      n++;
      @(negedge clk);
    end
    chk("wait_plus_backoff", n, TO + 1);
    repeat (230) @(negedge clk);
    rd(2'd0, v); chk("status_tmo", v, 32'h040);
    rd(2'd1, v); chk("count_tmo", v, 32'h0302);

    // reset pulse during WAIT_CAL
    do_reset(3'b000);
    repeat (10) @(negedge clk);
    rd(2'd0, v); chk("status_wait", v, 32'h010);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("pulse_readdata", readdata, 32'd0);
    chk("pulse_emif", {31'd0, emif_soft_reset_n}, 32'd0);
    chk("pulse_ready", {31'd0, mem_ready}, 32'd0);
    chk("pulse_irq", {31'd0, irq}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    rd(2'd1, v); chk("pulse_count", v, 32'd0);

    // loss of calibration
    do_reset(3'b011);
    wr(2'd2, 32'd2);
    wait_ready(50);
    cal_status = 3'b001;
    repeat (4) @(negedge clk);
    rd(2'd0, v); chk("status_after_lost", v[6:4], 32'd0);
    rd(2'd3, v); chk("irq_lost", v, IRQ_ON ? 32'd5 : 32'd0);
    chk("irq_out_lost", {31'd0, irq}, {31'd0, IRQ_ON});
    wr(2'd3, 32'd1);
    chk("irq_keep", {31'd0, irq}, {31'd0, IRQ_ON});
    wr(2'd3, 32'd4);
    chk("irq_lag", {31'd0, irq}, {31'd0, IRQ_ON});
    @(posedge clk);
    #1 chk("irq_clear", {31'd0, irq}, 32'd0);
    rd(2'd3, v); chk("irq_empty", v, 32'd0);

    // W1C colliding with ready_rise
    do_reset(3'b011);
    repeat (3) @(negedge clk);
    wr(2'd3, 32'd1);
    chk("w1c_ready", {31'd0, mem_ready}, 32'd1);
    rd(2'd3, v); chk("w1c_set_wins", v, IRQ_ON ? 32'd1 : 32'd0);

    // restart from FAILED
    do_reset(3'b100);
    repeat (40) @(negedge clk);
    cal_status = 3'b011;
    wr(2'd2, 32'd1);
    chk("restart_emif", {31'd0, emif_soft_reset_n}, 32'd0);
    rd(2'd0, v); chk("restart_status", v, 32'h003);
    rd(2'd1, v); chk("restart_count", v, 32'h0300);
    wait_ready(30);
    rd(2'd1, v); chk("restart_kept", v, 32'h0300);
    rd(2'd0, v); chk("restart_ready", v, 32'h123);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
